// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: captures the decoded control bundle, operands and
// instruction fields, gates control by the ARM condition check, and counts bubbles.
module id_exe_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              wb_en_in,
    input  logic              mem_r_in,
    input  logic              mem_w_in,
    input  logic              b_in,
    input  logic              s_in,
    input  logic [3:0]        exe_cmd_in,
    input  logic [3:0]        cond_in,
    input  logic [3:0]        status_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic              imm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm24_in,
    input  logic [3:0]        dest_in,
    output logic              wb_en,
    output logic              mem_r,
    output logic              mem_w,
    output logic              b,
    output logic              s,
    output logic [3:0]        exe_cmd,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] val_rn,
    output logic [DATA_W-1:0] val_rm,
    output logic              imm,
    output logic [11:0]       shift_operand,
    output logic [23:0]       signed_imm24,
    output logic [3:0]        dest,
    output logic              valid,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_e;

    logic w_n, w_z, w_c, w_v;
    logic w_cond_ok;

    logic              r_wb_en, r_mem_r, r_mem_w, r_b, r_s;
    logic [3:0]        r_exe_cmd;
    logic [DATA_W-1:0] r_pc, r_val_rn, r_val_rm;
    logic              r_imm;
    logic [11:0]       r_shift_operand;
    logic [23:0]       r_signed_imm24;
    logic [3:0]        r_dest;
    logic              r_valid;
    logic [CNT_W-1:0]  r_bubble_cnt;

    assign {w_n, w_z, w_c, w_v} = status_in;

    always_comb begin
        // NOTE: default first so every path assigns w_cond_ok; otherwise a latch is inferred.
        w_cond_ok = 1'b0;
        unique case (cond_e'(cond_in))
            COND_EQ: w_cond_ok = w_z;
            COND_NE: w_cond_ok = !w_z;
            COND_CS: w_cond_ok = w_c;
            COND_CC: w_cond_ok = !w_c;
            COND_MI: w_cond_ok = w_n;
            COND_PL: w_cond_ok = !w_n;
            COND_VS: w_cond_ok = w_v;
            COND_VC: w_cond_ok = !w_v;
            COND_HI: w_cond_ok = w_c && !w_z;
            COND_LS: w_cond_ok = !w_c || w_z;
            COND_GE: w_cond_ok = (w_n == w_v);
            COND_LT: w_cond_ok = (w_n != w_v);
            COND_GT: w_cond_ok = !w_z && (w_n == w_v);
            COND_LE: w_cond_ok = w_z || (w_n != w_v);
            COND_AL: w_cond_ok = 1'b1;
            COND_NV: w_cond_ok = 1'b0;
        endcase
    end

    // Priority per edge: rst > flush > freeze > load.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_wb_en         <= 1'b0;
            r_mem_r         <= 1'b0;
            r_mem_w         <= 1'b0;
            r_b             <= 1'b0;
            r_s             <= 1'b0;
            r_exe_cmd       <= '0;
            r_pc            <= '0;
            r_val_rn        <= '0;
            r_val_rm        <= '0;
            r_imm           <= 1'b0;
            r_shift_operand <= '0;
            r_signed_imm24  <= '0;
            r_dest          <= '0;
            r_valid         <= 1'b0;
            r_bubble_cnt    <= '0;
        end else if (flush) begin
            r_wb_en   <= 1'b0;
            r_mem_r   <= 1'b0;
            r_mem_w   <= 1'b0;
            r_b       <= 1'b0;
            r_s       <= 1'b0;
            r_exe_cmd <= '0;
            r_valid   <= 1'b0;
            if (r_bubble_cnt != {CNT_W{1'b1}}) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end else if (!freeze) begin
            r_wb_en         <= wb_en_in && w_cond_ok;
            r_mem_r         <= mem_r_in && w_cond_ok;
            r_mem_w         <= mem_w_in && w_cond_ok;
            r_b             <= b_in     && w_cond_ok;
            r_s             <= s_in     && w_cond_ok;
            r_exe_cmd       <= exe_cmd_in;
            r_pc            <= pc_in;
            r_val_rn        <= val_rn_in;
            r_val_rm        <= val_rm_in;
            r_imm           <= imm_in;
            r_shift_operand <= shift_operand_in;
            r_signed_imm24  <= signed_imm24_in;
            r_dest          <= dest_in;
            r_valid         <= 1'b1;
        end
    end

    assign wb_en         = r_wb_en;
    assign mem_r         = r_mem_r;
    assign mem_w         = r_mem_w;
    assign b             = r_b;
    assign s             = r_s;
    assign exe_cmd       = r_exe_cmd;
    assign pc            = r_pc;
    assign val_rn        = r_val_rn;
    assign val_rm        = r_val_rm;
    assign imm           = r_imm;
    assign shift_operand = r_shift_operand;
    assign signed_imm24  = r_signed_imm24;
    assign dest          = r_dest;
    assign valid         = r_valid;
    assign bubble_cnt    = r_bubble_cnt;

endmodule

// File: tb/tb_id_exe_reg.sv
// Self-checking bench for id_exe_reg: directed plan items plus randomized traffic
// compared against a behavioural model of the pipeline register.
module tb_id_exe_reg;

    localparam int DATA_W  = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst, freeze, flush;
    logic              wb_en_in, mem_r_in, mem_w_in, b_in, s_in;
    logic [3:0]        exe_cmd_in, cond_in, status_in;
    logic [DATA_W-1:0] pc_in, val_rn_in, val_rm_in;
    logic              imm_in;
    logic [11:0]       shift_operand_in;
    logic [23:0]       signed_imm24_in;
    logic [3:0]        dest_in;

    logic              wb_en, mem_r, mem_w, b, s;
    logic [3:0]        exe_cmd;
    logic [DATA_W-1:0] pc, val_rn, val_rm;
    logic              imm;
    logic [11:0]       shift_operand;
    logic [23:0]       signed_imm24;
    logic [3:0]        dest;
    logic              valid;
    logic [CNT_W-1:0]  bubble_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_exe_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .wb_en_in(wb_en_in), .mem_r_in(mem_r_in), .mem_w_in(mem_w_in),
        .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in),
        .cond_in(cond_in), .status_in(status_in), .pc_in(pc_in),
        .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
        .shift_operand_in(shift_operand_in), .signed_imm24_in(signed_imm24_in),
        .dest_in(dest_in),
        .wb_en(wb_en), .mem_r(mem_r), .mem_w(mem_w), .b(b), .s(s),
        .exe_cmd(exe_cmd), .pc(pc), .val_rn(val_rn), .val_rm(val_rm),
        .imm(imm), .shift_operand(shift_operand), .signed_imm24(signed_imm24),
        .dest(dest), .valid(valid), .bubble_cnt(bubble_cnt)
    );

    typedef struct {
        logic [4:0]        ctrl;   // {wb_en, mem_r, mem_w, b, s}
        logic [3:0]        exe_cmd;
        logic [DATA_W-1:0] pc, val_rn, val_rm;
        logic [40:0]       fields; // {imm, shift_operand, signed_imm24, dest}
        logic              valid;
        int                cnt;
        bit                data_known;
    } model_t;

    model_t m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ARM rule: codes come in pairs, the odd code is the negation of the even one.
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, base;
        {n, z, c, v} = nzcv;
        case (cond >> 1)
            0: base = z;
            1: base = c;
            2: base = n;
            3: base = v;
            4: base = c & ~z;
            5: base = (n ~^ v);
            6: base = ~z & (n ~^ v);
            default: base = 1'b1;
        endcase
        return cond[0] ? ~base : base;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".ctrl"},  {59'd0, wb_en, mem_r, mem_w, b, s}, {59'd0, m.ctrl});
        check({tag, ".cmd"},   {60'd0, exe_cmd}, {60'd0, m.exe_cmd});
        check({tag, ".valid"}, {63'd0, valid}, {63'd0, m.valid});
        check({tag, ".cnt"},   {60'd0, bubble_cnt}, 64'(m.cnt));
        if (m.data_known) begin
            check({tag, ".pc"},     {32'd0, pc}, {32'd0, m.pc});
            check({tag, ".rn"},     {32'd0, val_rn}, {32'd0, m.val_rn});
            check({tag, ".rm"},     {32'd0, val_rm}, {32'd0, m.val_rm});
            check({tag, ".fields"}, {23'd0, imm, shift_operand, signed_imm24, dest},
                  {23'd0, m.fields});
        end
    endtask

    // Advance one clock: predict from current inputs, then compare after the edge.
    task automatic tick(input string tag);
        model_t nx;
        logic ok;
        nx = m;
        ok = cond_holds(cond_in, status_in);
        if (rst) begin
            nx.ctrl = '0; nx.exe_cmd = '0; nx.pc = '0; nx.val_rn = '0; nx.val_rm = '0;
            nx.fields = '0; nx.valid = 1'b0; nx.cnt = 0; nx.data_known = 1'b1;
        end else if (flush) begin
            nx.ctrl = '0; nx.exe_cmd = '0; nx.valid = 1'b0; nx.data_known = 1'b0;
            nx.cnt = (m.cnt < CNT_MAX) ? m.cnt + 1 : CNT_MAX;
        end else if (!freeze) begin
            nx.ctrl       = ok ? {wb_en_in, mem_r_in, mem_w_in, b_in, s_in} : 5'b0;
            nx.exe_cmd    = exe_cmd_in;
            nx.pc         = pc_in;
            nx.val_rn     = val_rn_in;
            nx.val_rm     = val_rm_in;
            nx.fields     = {imm_in, shift_operand_in, signed_imm24_in, dest_in};
            nx.valid      = 1'b1;
            nx.data_known = 1'b1;
        end
        @(posedge clk);
        #1;
        m = nx;
        compare_all(tag);
    endtask

    task automatic rand_inputs();
        {wb_en_in, mem_r_in, mem_w_in, b_in, s_in} = 5'($urandom);
        exe_cmd_in       = 4'($urandom);
        cond_in          = 4'($urandom);
        status_in        = 4'($urandom);
        pc_in            = $urandom;
        val_rn_in        = $urandom;
        val_rm_in        = $urandom;
        imm_in           = 1'($urandom);
        shift_operand_in = 12'($urandom);
        signed_imm24_in  = 24'($urandom);
        dest_in          = 4'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt_before;
        logic [DATA_W-1:0] a_pc;
        m = '{default: '0};
        m.data_known = 1'b0;
        rst = 1'b1; freeze = 1'b0; flush = 1'b0;
        rand_inputs();
        @(negedge clk);

        // Reset, then reset together with flush.
        tick("reset");
        check("reset.valid0", {63'd0, valid}, 64'd0);
        flush = 1'b1;
        tick("reset_flush");
        check("reset_flush.cnt0", {60'd0, bubble_cnt}, 64'd0);
        rst = 1'b0; flush = 1'b0;

        // Normal load with AL.
        rand_inputs();
        cond_in = 4'b1110; wb_en_in = 1'b1; exe_cmd_in = 4'b0001; pc_in = 32'h10; dest_in = 4'd3;
        tick("load");
        check("load.wb_en", {63'd0, wb_en}, 64'd1);
        check("load.pc", {32'd0, pc}, 64'h10);
        check("load.dest", {60'd0, dest}, 64'd3);

        // EQ gating: fails with Z=0, passes with Z=1.
        rand_inputs();
        cond_in = 4'b0000; status_in = 4'b0000; mem_w_in = 1'b1; b_in = 1'b1; exe_cmd_in = 4'b0110;
        tick("eq_fail");
        check("eq_fail.mem_w_b", {62'd0, mem_w, b}, 64'd0);
        check("eq_fail.valid", {63'd0, valid}, 64'd1);
        check("eq_fail.cmd", {60'd0, exe_cmd}, 64'd6);
        status_in = 4'b0100;
        tick("eq_pass");
        check("eq_pass.mem_w_b", {62'd0, mem_w, b}, 64'd3);

        // Freeze holds A for three cycles, then flush beats freeze.
        rand_inputs();
        cond_in = 4'b1110;
        a_pc = pc_in;
        tick("load_a");
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            tick("freeze");
        end
        check("freeze.pc_a", {32'd0, pc}, {32'd0, a_pc});
        cnt_before = m.cnt;
        flush = 1'b1;
        tick("freeze_flush");
        check("freeze_flush.valid", {63'd0, valid}, 64'd0);
        check("freeze_flush.cnt", {60'd0, bubble_cnt}, 64'(cnt_before + 1));
        freeze = 1'b0; flush = 1'b0;

        // Full condition table sweep.
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                rand_inputs();
                wb_en_in = 1'b1; cond_in = 4'(c); status_in = 4'(f);
                tick("sweep");
                if (c == 15) check("sweep.nv", {63'd0, wb_en}, 64'd0);
            end
        end

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            rand_inputs();
            rst    = ($urandom_range(0, 49) == 0);
            flush  = ($urandom_range(0, 7) == 0);
            freeze = ($urandom_range(0, 5) == 0);
            tick("rand");
        end

        // Saturation: 20 flushes on a 4-bit counter.
        rst = 1'b1; flush = 1'b0; freeze = 1'b0;
        tick("sat_reset");
        rst = 1'b0; flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_inputs();
            tick("sat");
        end
        check("sat.cnt15", {60'd0, bubble_cnt}, 64'd15);
        flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_exe_reg.md
Name: id_exe_reg

Overview:
- Pipeline register between the decode stage (control unit plus register file read) and the execute stage.
- Captures the decoder control bundle (WB_EN, MEM_R, MEM_W, B, S, EXE_CMD) together with operands and instruction fields.
- Gates the control bundle with an ARM condition-code check against the current NZCV flags.
- Supports freeze (hazard stall) and flush (taken branch), and keeps a saturating bubble counter for performance debug.

Parameters:
- DATA_W, 32, width of PC and register operand values.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  hold all registered outputs (hazard stall).
- flush  in  1  load a bubble (taken branch in EXE).
- wb_en_in, mem_r_in, mem_w_in, b_in, s_in  in  1 each  decoder control bits.
- exe_cmd_in  in  4  decoder ALU command.
- cond_in  in  4  instruction condition field [31:28].
- status_in  in  4  current flags {N,Z,C,V}.
- pc_in  in  DATA_W  PC of the decoded instruction.
- val_rn_in, val_rm_in  in  DATA_W each  register operands.
- imm_in  in  1  immediate flag (I bit).
- shift_operand_in  in  12  shifter operand field.
- signed_imm24_in  in  24  branch offset field.
- dest_in  in  4  destination register index.
- wb_en, mem_r, mem_w, b, s  out  1 each  registered, gated control bits.
- exe_cmd  out  4  registered ALU command.
- pc, val_rn, val_rm  out  DATA_W each  registered values.
- imm  out  1  registered immediate flag.
- shift_operand  out  12  registered shifter operand field.
- signed_imm24  out  24  registered branch offset field.
- dest  out  4  registered destination register index.
- valid  out  1  1 = real instruction in EXE, 0 = bubble.
- bubble_cnt  out  CNT_W  saturating count of bubbles inserted.

Behaviour:
- Reset (rst=1 at a rising edge): every output is 0, including valid and bubble_cnt. Reset overrides flush and freeze.
- Condition check (combinational, on cond_in vs status_in {N,Z,C,V}):
  - 0000 EQ: Z. 0001 NE: !Z. 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N. 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C & !Z. 1001 LS: !C | Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z & (N==V). 1101 LE: Z | (N!=V).
  - 1110 AL: 1. 1111: 0 (treated as never).
- Gating: if the condition fails, wb_en, mem_r, mem_w, b and s are loaded as 0. exe_cmd, data and fields are still captured, and valid is still loaded as 1.
- Update priority each edge: rst > flush > freeze > normal load.
- flush=1: all control bits = 0, exe_cmd = 0, valid = 0. Data and field outputs may load the inputs but are don't-care. bubble_cnt increments.
- freeze=1 (no flush): all outputs hold their values. bubble_cnt unchanged.
- Normal load: all outputs take the gated inputs one cycle after presentation (latency 1). valid = 1.
- Condition-failed instruction: valid=1 with control zeroed. It does not count as a bubble.
- bubble_cnt: +1 per flush edge; saturates at 2^CNT_W-1 and does not wrap.
- No combinational path from any input to any output.

Test Plan:
- Reset → after rst high for one edge, every output is 0. With rst and flush high together, outputs stay 0 and bubble_cnt stays 0.
- Normal load: cond=1110, wb_en_in=1, exe_cmd_in=0001, pc_in=0x10, dest_in=3 → next edge: wb_en=1, exe_cmd=0001, pc=0x10, dest=3, valid=1.
- Condition gating: cond=0000 (EQ) with status_in=0000, mem_w_in=1, b_in=1 → mem_w=0, b=0, valid=1, exe_cmd captured. With status_in=0100, mem_w=1 and b=1.
- Freeze/flush priority:
  - Load A, then freeze=1 for 3 cycles with new inputs → outputs stay A.
  - Then freeze=1 and flush=1 together → valid=0, all control bits 0, bubble_cnt incremented by 1.
- Condition table sweep: all 16 cond codes × all 16 NZCV values → wb_en output matches the table. Code 1111 always gives wb_en=0.
- Counter saturation (CNT_W=4) → 20 consecutive flushes leave bubble_cnt=15.
